dram_cmd_arbiter: RTL

- Shares the single DRAM command bus among NUM_BANKS per-bank controllers, each gated by its own per-bank timing counter (`bank_ready`).
- Grants at most one command per cycle using round-robin.
- Enforces the inter-bank constraints tRRD, tCCD and tFAW that no single bank can see.
- Sequences all-bank refresh: drain, issue REF, then wait tRFC.

---
 rtl/dram_cmd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_arbiter.sv
// Round-robin arbiter sharing one DRAM command bus among per-bank controllers,
// enforcing tRRD/tCCD/tFAW and sequencing all-bank refresh (drain, REF, tRFC).
// Optional macro DRAM_ARB_COL_PRIORITY_EN: eligible RD/WR beat ACT/PRE.
module dram_cmd_arbiter #(
  parameter int NUM_BANKS  = 8,
  parameter int CYCLE_TRRD = 4,
  parameter int CYCLE_TCCD = 4,
  parameter int CYCLE_TFAW = 20,
  parameter int CYCLE_TRFC = 52
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANKS-1:0]         req,
  input  logic [3*NUM_BANKS-1:0]       cmd_in,
  input  logic [NUM_BANKS-1:0]         bank_ready,
  input  logic                         banks_idle,
  input  logic                         ref_req,
  output logic [NUM_BANKS-1:0]         gnt,
  output logic                         cmd_valid,
  output logic [2:0]                   cmd_out,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic                         ref_ack
);

  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int TRRD_W    = $clog2(CYCLE_TRRD + 1);
  localparam int TCCD_W    = $clog2(CYCLE_TCCD + 1);
  localparam int TFAW_W    = $clog2(CYCLE_TFAW + 1);
  localparam int TRFC_W    = $clog2(CYCLE_TRFC + 1);
  localparam int FAW_SLOTS = 4;

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [BANK_W-1:0] ptr;
  logic [TRRD_W-1:0] trrd_cnt;
  logic [TCCD_W-1:0] tccd_cnt;
  logic [TFAW_W-1:0] faw_cnt [FAW_SLOTS];
  logic [TRFC_W-1:0] trfc_cnt;

  // FSM-derived permissions and strobes
  logic act_allowed;
  logic col_allowed;
  logic pre_allowed;
  logic ref_issue;
  logic ref_done;

  // Timing qualifiers
  logic       act_timing_ok;
  logic       col_timing_ok;
  logic       faw_free;
  logic [1:0] faw_sel;

  // Per-bank decode and arbitration
  logic [2:0]           bank_code [NUM_BANKS];
  logic [NUM_BANKS-1:0] elig_act;
  logic [NUM_BANKS-1:0] elig_col;
  logic [NUM_BANKS-1:0] elig_pre;
  logic [NUM_BANKS-1:0] elig;
  logic [NUM_BANKS-1:0] cand;
  logic [NUM_BANKS-1:0] gnt_vec;
  logic [BANK_W-1:0]    rr_idx;
  logic [BANK_W-1:0]    gnt_idx;
  logic                 gnt_found;
  logic [2:0]           gnt_code;
  logic                 issue_act;
  logic                 issue_col;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Timing qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    faw_free = 1'b0;
    faw_sel  = 2'd0;
    // Descending scan so the lowest-index free slot is the one that sticks.
    for (int s = FAW_SLOTS - 1; s >= 0; s--) begin
      if (faw_cnt[s] == '0) begin
        faw_free = 1'b1;
        faw_sel  = 2'(s);
      end
    end
  end

  assign act_timing_ok = (trrd_cnt == '0) && faw_free;
  assign col_timing_ok = (tccd_cnt == '0);

  // ---------------------------------------------------------------------------
  // Per-bank eligibility
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic is_act;
    logic is_col;
    logic is_pre;
    logic live;

    assign bank_code[gi] = cmd_in[3*gi +: 3];
    assign is_act        = (bank_code[gi] == CMD_ACT);
    assign is_col        = (bank_code[gi] == CMD_RD) || (bank_code[gi] == CMD_WR);
    assign is_pre        = (bank_code[gi] == CMD_PRE);
    assign live          = req[gi] & bank_ready[gi];

    assign elig_act[gi] = live & is_act & act_allowed & act_timing_ok;
    assign elig_col[gi] = live & is_col & col_allowed & col_timing_ok;
    assign elig_pre[gi] = live & is_pre & pre_allowed;
    assign elig[gi]     = elig_act[gi] | elig_col[gi] | elig_pre[gi];
  end

`ifdef DRAM_ARB_COL_PRIORITY_EN
  // Column commands win as a class; the shared pointer orders banks within it.
  assign cand = (|elig_col) ? elig_col : elig;
`else
  assign cand = elig;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick starting at ptr, wrapping modulo NUM_BANKS
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int off = 0; off < NUM_BANKS; off++) begin
      rr_idx = ptr + BANK_W'(off);
      if (!gnt_found && cand[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (gnt_found) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  // The grant is combinational, so hold it low while reset is asserted.
  assign gnt       = rst_n ? gnt_vec : '0;
  assign gnt_code  = bank_code[gnt_idx];
  assign issue_act = gnt_found && (gnt_code == CMD_ACT);
  assign issue_col = gnt_found && ((gnt_code == CMD_RD) || (gnt_code == CMD_WR));

  // ---------------------------------------------------------------------------
  // Refresh FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_NORMAL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Refresh FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NORMAL: if (ref_req) state_next = ST_DRAIN;
      ST_DRAIN:  if (banks_idle && !gnt_found) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT:   if (trfc_cnt == '0) state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  // Refresh FSM: outputs. A pending refresh blocks ACT in the very cycle it is seen.
  always_comb begin
    act_allowed = 1'b0;
    col_allowed = 1'b0;
    pre_allowed = 1'b0;
    ref_issue   = 1'b0;
    ref_done    = 1'b0;
    case (state_reg)
      ST_NORMAL: begin
        act_allowed = !ref_req;
        col_allowed = 1'b1;
        pre_allowed = 1'b1;
      end
      ST_DRAIN:  pre_allowed = 1'b1;
      ST_ISSUE:  ref_issue   = 1'b1;
      ST_WAIT:   ref_done    = (trfc_cnt == '0);
      default:   ;
    endcase
  end

  assign ref_ack = ref_done;

  // ---------------------------------------------------------------------------
  // Round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_found) begin
      ptr <= gnt_idx + BANK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-bank timing counters (load on issue overrides decrement)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trrd_cnt <= '0;
    end else if (issue_act) begin
      trrd_cnt <= TRRD_W'(CYCLE_TRRD - 1);
    end else if (trrd_cnt != '0) begin
      trrd_cnt <= trrd_cnt - TRRD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tccd_cnt <= '0;
    end else if (issue_col) begin
      tccd_cnt <= TCCD_W'(CYCLE_TCCD - 1);
    end else if (tccd_cnt != '0) begin
      tccd_cnt <= tccd_cnt - TCCD_W'(1);
    end
  end

  for (gi = 0; gi < FAW_SLOTS; gi++) begin : g_faw
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        faw_cnt[gi] <= '0;
      end else if (issue_act && (faw_sel == 2'(gi))) begin
        faw_cnt[gi] <= TFAW_W'(CYCLE_TFAW - 1);
      end else if (faw_cnt[gi] != '0) begin
        faw_cnt[gi] <= faw_cnt[gi] - TFAW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trfc_cnt <= '0;
    end else if (ref_issue) begin
      trfc_cnt <= TRFC_W'(CYCLE_TRFC - 1);
    end else if (trfc_cnt != '0) begin
      trfc_cnt <= trfc_cnt - TRFC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered command bus; fields are zeroed in cycles with no command.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_out   <= 3'd0;
      cmd_bank  <= '0;
    end else if (gnt_found) begin
      cmd_valid <= 1'b1;
      cmd_out   <= gnt_code;
      cmd_bank  <= gnt_idx;
    end else if (ref_issue) begin
      cmd_valid <= 1'b1;
      cmd_out   <= CMD_REF;
      cmd_bank  <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_out   <= 3'd0;
      cmd_bank  <= '0;
    end
  end

endmodule
